// File: rtl/score_neighbour_fetch.sv
// score_neighbour_fetch
//   Fetches the three neighbour scores (diag, up, left) of cell (i,j) of an
//   (N+1)x(N+1) row-major score matrix held in a RAM with fixed read latency.
//   Row-0 / column-0 neighbours are synthesized as (r+c)*GAP instead of read.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake, req_i/req_j = target cell
//   ram_en/ram_addr/ram_data RAM read port, data valid RD_LAT cycles after ram_en
//   out_valid/out_ready      result handshake
//   diag/up/left             neighbour scores, err = request out of range
module score_neighbour_fetch #(
    parameter int        SCORE_W = 9,
    parameter int        N       = 128,
    parameter int        IDX_W   = 8,
    parameter int        ADDR_W  = 15,
    parameter int        RD_LAT  = 1,
    parameter int signed GAP     = -1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IDX_W-1:0]   req_i,
    input  logic [IDX_W-1:0]   req_j,
    output logic               ram_en,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [SCORE_W-1:0] ram_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] diag,
    output logic [SCORE_W-1:0] up,
    output logic [SCORE_W-1:0] left,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] ri, rj, si, sj;
    logic [2:0]       pend_q;         // reads not yet issued, bit0=diag 1=up 2=left
    logic [1:0]       slot_q;         // slot of the read currently on ram_addr

    // tag pipeline: stage s holds the read issued s cycles ago
    logic [RD_LAT:1]      tag_vld;
    logic [RD_LAT:1][1:0] tag_slot;

    logic                          legal;
    logic [2:0]                    need, mask, onehot;
    logic [1:0]                    sel;
    logic [2:0][SCORE_W-1:0]       bnd;
    logic [2:0][ADDR_W-1:0]        addr;
    logic                          early_inflight;

    assign req_ready = (state == IDLE);
    assign out_valid = (state == OUT);
    assign ram_en    = (state == ISSUE);

    // In IDLE the live request indices drive the neighbour maths so the first
    // read can be launched on the accepting edge.
    assign si = (state == IDLE) ? req_i : ri;
    assign sj = (state == IDLE) ? req_j : rj;

    always_comb begin
        int ii, jj;
        int r [3];
        int c [3];
        ii    = int'(si);
        jj    = int'(sj);
        legal = (ii >= 1) && (ii <= N) && (jj >= 1) && (jj <= N);
        r[0] = ii - 1; c[0] = jj - 1;
        r[1] = ii - 1; c[1] = jj;
        r[2] = ii;     c[2] = jj - 1;
        need = '0;
        bnd  = '0;
        addr = '0;
        for (int s = 0; s < 3; s++) begin
            need[s] = legal && (r[s] != 0) && (c[s] != 0);
            bnd[s]  = SCORE_W'((r[s] + c[s]) * GAP);
            addr[s] = ADDR_W'(r[s] * (N + 1) + c[s]);
        end
    end

    // next read = lowest pending slot, which gives the diag, up, left order
    always_comb begin
        mask   = (state == IDLE) ? need : pend_q;
        sel    = 2'd0;
        onehot = 3'b000;
        if (mask[0]) begin
            sel = 2'd0; onehot = 3'b001;
        end else if (mask[1]) begin
            sel = 2'd1; onehot = 3'b010;
        end else if (mask[2]) begin
            sel = 2'd2; onehot = 3'b100;
        end
    end

    // Only the final stage may still be busy when WAIT exits: it is captured
    // on the same edge that moves to OUT.
    always_comb begin
        early_inflight = 1'b0;
        for (int s = 1; s < RD_LAT; s++)
            early_inflight = early_inflight | tag_vld[s];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid) state_nxt = (!legal || need == 3'b000) ? OUT : ISSUE;
            ISSUE: if (pend_q == 3'b000) state_nxt = WAIT;
            WAIT:  if (!early_inflight) state_nxt = OUT;
            OUT:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ri       <= '0;
            rj       <= '0;
            pend_q   <= '0;
            slot_q   <= '0;
            ram_addr <= '0;
            tag_vld  <= '0;
            tag_slot <= '0;
            diag     <= '0;
            up       <= '0;
            left     <= '0;
            err      <= 1'b0;
        end else begin
            tag_vld[1]  <= ram_en;
            tag_slot[1] <= slot_q;
            for (int s = 2; s <= RD_LAT; s++) begin
                tag_vld[s]  <= tag_vld[s-1];
                tag_slot[s] <= tag_slot[s-1];
            end

            if (state == IDLE && req_valid) begin
                ri   <= req_i;
                rj   <= req_j;
                err  <= !legal;
                // boundary values preloaded; RAM returns overwrite read slots
                diag <= legal ? bnd[0] : '0;
                up   <= legal ? bnd[1] : '0;
                left <= legal ? bnd[2] : '0;
                pend_q <= need & ~onehot;
                if (need != 3'b000) begin
                    ram_addr <= addr[sel];
                    slot_q   <= sel;
                end
            end else if (state == ISSUE && pend_q != 3'b000) begin
                ram_addr <= addr[sel];
                slot_q   <= sel;
                pend_q   <= pend_q & ~onehot;
            end

            if (tag_vld[RD_LAT]) begin
                case (tag_slot[RD_LAT])
                    2'd0:    diag <= ram_data;
                    2'd1:    up   <= ram_data;
                    default: left <= ram_data;
                endcase
            end
        end
    end

endmodule
